// File: rtl/rand_candidate_builder.sv
// Builds an odd, full-width prime candidate from PRIME_WIDTH/WORD_WIDTH random words,
// rejecting repeated words and latching a sticky fault when the source looks stuck.
module rand_candidate_builder #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned PRIME_WIDTH  = 256,
  parameter int unsigned REPEAT_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  rand_in,
  input  logic                   cand_ready,
  output logic                   cand_valid,
  output logic [PRIME_WIDTH-1:0] candidate,
  output logic                   busy,
  output logic                   src_fault
);

  localparam int unsigned N       = PRIME_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam int unsigned REP_W   = $clog2(REPEAT_LIMIT + 1);
  localparam int unsigned SHIFT_W = PRIME_WIDTH - WORD_WIDTH;

  // Top two bits make the candidate full width; bit 0 makes it odd.
  localparam logic [PRIME_WIDTH-1:0] FORCE_MASK =
    {2'b11, {(PRIME_WIDTH-3){1'b0}}, 1'b1};

  generate
    if ((PRIME_WIDTH % WORD_WIDTH) != 0) begin : g_bad_multiple
      $error("PRIME_WIDTH must be an integer multiple of WORD_WIDTH");
    end
    if (PRIME_WIDTH < 2 * WORD_WIDTH) begin : g_bad_width
      $error("PRIME_WIDTH must be at least 2*WORD_WIDTH");
    end
    if (REPEAT_LIMIT < 1) begin : g_bad_limit
      $error("REPEAT_LIMIT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SHIFT_W-1:0]     shift_q;
  logic [WORD_WIDTH-1:0]  last_word;
  logic [CNT_W-1:0]       word_cnt;
  logic [REP_W-1:0]       rep_cnt;

  logic                   accept_c;
  logic                   reject_c;
  logic                   last_word_c;
  logic [PRIME_WIDTH-1:0] shift_next_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and word accept/reject decisions
  always_comb begin
    state_next   = state;
    accept_c     = 1'b0;
    reject_c     = 1'b0;
    last_word_c  = 1'b0;
    shift_next_c = {shift_q, rand_in};

    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if ((word_cnt == '0) || (rand_in != last_word)) begin
          accept_c = 1'b1;
          if (word_cnt == CNT_W'(N - 1)) begin
            last_word_c = 1'b1;
            state_next  = HOLD;
          end
        end else begin
          reject_c = 1'b1;
          if (rep_cnt == REP_W'(REPEAT_LIMIT - 1)) begin
            state_next = FAULT;
          end
        end
      end
      HOLD: begin
        if (cand_valid && cand_ready) begin
          state_next = start ? COLLECT : IDLE;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word datapath; counters stay cleared outside COLLECT so every entry starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      last_word <= '0;
      word_cnt  <= '0;
      rep_cnt   <= '0;
    end else if (state != COLLECT) begin
      word_cnt <= '0;
      rep_cnt  <= '0;
    end else if (accept_c) begin
      shift_q   <= shift_next_c[SHIFT_W-1:0];
      last_word <= rand_in;
      word_cnt  <= word_cnt + CNT_W'(1);
      rep_cnt   <= '0;
    end else if (reject_c) begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate  <= '0;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      src_fault  <= 1'b0;
    end else begin
      if (last_word_c) begin
        candidate <= shift_next_c | FORCE_MASK;
      end
      cand_valid <= (state_next == HOLD);
      busy       <= (state_next == COLLECT);
      src_fault  <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_rand_candidate_builder.sv
// Directed bench for rand_candidate_builder: expected candidates are queued at
// request time and popped when cand_valid is observed.
module tb_rand_candidate_builder;

  localparam int unsigned WW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned RL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] rand_in;
  logic          cand_ready;
  logic          cand_valid;
  logic [PW-1:0] candidate;
  logic          busy;
  logic          src_fault;

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] held;

  rand_candidate_builder #(
    .WORD_WIDTH  (WW),
    .PRIME_WIDTH (PW),
    .REPEAT_LIMIT(RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rand_in   (rand_in),
    .cand_ready(cand_ready),
    .cand_valid(cand_valid),
    .candidate (candidate),
    .busy      (busy),
    .src_fault (src_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic feed(input logic [WW-1:0] w);
    rand_in = w;
    tick();
  endtask

  task automatic begin_collect(input logic [PW-1:0] exp_cand);
    exp_q.push_back(exp_cand);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_cand(input string tag);
    logic [PW-1:0] e;
    check({tag, "_valid"}, PW'(cand_valid), PW'(1));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, PW'(1), PW'(0));
      e = 'x;
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cand"}, candidate, e);
    end
    held = e;
  endtask

  task automatic handshake();
    cand_ready = 1'b1;
    tick();
    cand_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rand_in = '0; cand_ready = 1'b0; held = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", PW'(cand_valid), PW'(0));
    check("rst_busy",  PW'(busy),       PW'(0));
    check("rst_fault", PW'(src_fault),  PW'(0));
    check("rst_cand",  candidate,       PW'(0));

    // Basic two-word candidate, latency N after COLLECT entry
    begin_collect(64'hD2345678_00000003);
    check("t2_busy_entry", PW'(busy), PW'(1));
    feed(32'h12345678);
    check("t2_not_yet", PW'(cand_valid), PW'(0));
    feed(32'h00000002);
    expect_cand("t2");
    check("t2_busy_hold", PW'(busy), PW'(0));

    // Backpressure: candidate stable while rand_in toggles
    for (int i = 0; i < 10; i++) begin
      feed($urandom());
      check("t3_stable_valid", PW'(cand_valid), PW'(1));
      check("t3_stable_cand", candidate, held);
    end
    handshake();
    check("t3_drop_valid", PW'(cand_valid), PW'(0));
    check("t3_idle_busy",  PW'(busy),       PW'(0));
    check("t3_keep_cand",  candidate,       held);

    // Repeated words are rejected, each adding a cycle
    begin_collect(64'hEAAA0001_0F0F0F0F);
    feed(32'hAAAA0001);
    feed(32'hAAAA0001);
    feed(32'hAAAA0001);
    check("t4_not_yet", PW'(cand_valid), PW'(0));
    feed(32'h0F0F0F0F);
    expect_cand("t4");
    check("t4_no_fault", PW'(src_fault), PW'(0));
    handshake();

    // Stuck source: fault after REPEAT_LIMIT repeats, sticky until reset
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) feed(32'h55555555);
    check("t5_pre_fault", PW'(src_fault), PW'(0));
    feed(32'h55555555);
    check("t5_fault",       PW'(src_fault),  PW'(1));
    check("t5_fault_valid", PW'(cand_valid), PW'(0));
    check("t5_fault_busy",  PW'(busy),       PW'(0));
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; tick(); start = 1'b0; tick();
      check("t5_sticky", PW'(src_fault), PW'(1));
      check("t5_sticky_busy", PW'(busy), PW'(0));
    end
    rst = 1'b1;
    #1;
    check("t5_rst_clear", PW'(src_fault), PW'(0));
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back candidates via handshake with start held
    begin_collect(64'hD1111111_22222223);
    feed(32'h11111111);
    feed(32'h22222222);
    expect_cand("t6a");
    exp_q.push_back(64'hC0000000_00000001);
    cand_ready = 1'b1; start = 1'b1;
    tick();
    cand_ready = 1'b0; start = 1'b0;
    check("t6_b2b_valid", PW'(cand_valid), PW'(0));
    check("t6_b2b_busy",  PW'(busy),       PW'(1));
    feed(32'h80000000);
    feed(32'h00000000);
    expect_cand("t6b");
    handshake();

    // Asynchronous reset mid-collection, then no stale word leaks through
    start = 1'b1; tick(); start = 1'b0;
    feed(32'hDEADBEEF);
    check("t1_busy_mid", PW'(busy), PW'(1));
    rst = 1'b1;
    #1;
    check("t1_async_busy",  PW'(busy),       PW'(0));
    check("t1_async_valid", PW'(cand_valid), PW'(0));
    check("t1_async_cand",  candidate,       PW'(0));
    check("t1_async_fault", PW'(src_fault),  PW'(0));
    tick();
    rst = 1'b0;
    tick();
    begin_collect(64'hC0000004_00000009);
    feed(32'h00000004);
    feed(32'h00000008);
    expect_cand("t6c");
    handshake();
    check("sb_drained", PW'(exp_q.size()), PW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
